// File: rtl/weight_update_module_pkg.sv
// Shared constants and FSM encoding for the weight update block.
package weight_update_module_pkg;

  // Q6.10 signed fixed-point format
  localparam int unsigned QW        = 16;
  localparam int unsigned FRAC_BITS = 10;

  // Saturation limits for a 16-bit signed result
  localparam logic [QW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [QW-1:0] SAT_MIN = 16'h8000;

  localparam int unsigned N_WEIGHTS_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StUpdate = 2'd1,
    StDone   = 2'd2
  } state_t;

endpackage

// File: rtl/weight_update_module_sat_sub16.sv
// Saturating 16-bit signed subtractor: y = clamp(a - b).
module sat_sub16
  import weight_update_module_pkg::*;
(
  input  logic [QW-1:0] a,
  input  logic [QW-1:0] b,
  output logic [QW-1:0] y
);

  logic [QW:0] diff;

  // One extra sign bit; bits [16:15] disagreeing means the result left the 16-bit range
  always_comb begin
    diff = {a[QW-1], a} - {b[QW-1], b};
    y    = diff[QW-1:0];
    if (diff[QW] != diff[QW-1]) begin
      y = diff[QW] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/weight_update_module.sv
// Weight bank with a sequential saturating update pass driven by a delta-weight stream.
module weight_update_module
  import weight_update_module_pkg::*;
#(
  parameter int unsigned N_WEIGHTS = N_WEIGHTS_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(N_WEIGHTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [QW-1:0]     ld_data,
  input  logic              start,
  input  logic              deltaw_valid,
  input  logic [QW-1:0]     deltaw,
  output logic              deltaw_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [QW-1:0]     rd_weight,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_WEIGHTS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [QW-1:0]     w_q [N_WEIGHTS];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [QW-1:0]     w_wdata;
  logic [QW-1:0]     sub_y;

  sat_sub16 u_sat_sub16 (
    .a (w_q[idx_q]),
    .b (deltaw),
    .y (sub_y)
  );

  // Next-state, counter and single weight-write port selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_we    = 1'b0;
    w_waddr = idx_q;
    w_wdata = sub_y;
    unique case (state_q)
      StIdle: begin
        // A load coinciding with start lands on the same edge the pass begins
        if (ld_en) begin
          w_we    = 1'b1;
          w_waddr = ld_addr;
          w_wdata = ld_data;
        end
        if (start) begin
          state_d = StUpdate;
          idx_d   = '0;
        end
      end
      StUpdate: begin
        if (deltaw_valid) begin
          w_we = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and beat index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Weight bank storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_WEIGHTS); i++) begin
        w_q[i] <= '0;
      end
    end else if (w_we) begin
      w_q[w_waddr] <= w_wdata;
    end
  end

  // Status outputs decoded from state; read port is combinational (pre-edge value)
  always_comb begin
    deltaw_ready = (state_q == StUpdate);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    rd_weight    = w_q[rd_addr];
  end

endmodule
